serial_multdiv: RTL and testbench
=================================

// Module: serial_multdiv
// PURPOSE
//  Iterative 32-bit multiply/divide unit for the MIPS core.
//  Computes one product or quotient bit per clock.
//  Responds to a single-cycle start pulse and raises done when its result registers are valid.
//  Pipeline control (HI/LO writeback, stall on mfhi/mflo) is the requester and
//  sits upstream of this block.
// PARAMETERS
//  WIDTH   32   operand width; prodh/prodl are WIDTH each; iteration count = WIDTH
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      synchronous, active-high reset
//  start         in   1      1-cycle request; operands/controls sampled same edge
//  multdivb      in   1      1 = multiply, 0 = divide
//  signedop      in   1      1 = two's-complement operands, 0 = unsigned
//  x             in   WIDTH  multiplicand / dividend
//  y             in   WIDTH  multiplier / divisor
//  prodh         out  WIDTH  mult: product[63:32]; div: remainder
//  prodl         out  WIDTH  mult: product[31:0];  div: quotient
//  done          out  1      result valid; held until next accepted start or reset
//  dividebyzero  out  1      divide with y==0; valid while done=1
// BEHAVIOUR
//  Reset (sync, active-high):
//   - state=IDLE; prodh=prodl=0; done=0; dividebyzero=0.
//   - Reset mid-operation aborts the operation with no result written.
//  States: IDLE -> RUN -> FIX -> DONE.
//  IDLE/DONE, start=1 (edge E0):
//   - latch multdivb, signedop.
//   - latch |x|, |y| (magnitudes only if signedop=1), sign(x), sign(y).
//   - clear accumulator and counter; done<=0; go to RUN.
//  RUN: WIDTH edges (E1..E32), counter 0..WIDTH-1.
//   - mult: shift-add, 2*WIDTH-bit accumulator.
//   - div: restoring shift-subtract; quotient bit = 1 when partial remainder >= |y|.
//  FIX (E33): apply sign correction, then write prodh/prodl, dividebyzero; done<=1; go to DONE.
//   - Result latency: done=1 after edge E33, i.e. 33 cycles after the start edge.
//   - mult signed: negate the 64-bit product when sign(x)^sign(y).
//   - div signed: negate the quotient when sign(x)^sign(y); the remainder takes sign(x) (MIPS rules).
//   - div y==0: dividebyzero=1, prodl=FFFFFFFF, prodh=x (raw x); no sign fix; same latency.
//   - signed 80000000 / FFFFFFFF: quotient=80000000, remainder=0; no flag.
//  DONE: outputs held stable until the next start edge. On that edge done falls and a new operation begins.
//  Busy / output rules:
//   - start in RUN or FIX is ignored: no restart, no operand resample.
//   - prodh/prodl change only in FIX; intermediate values are never visible on the outputs.
//   - done and start are never both acted on twice: done=0 from the cycle after the start edge until FIX.
//  Widths: all arithmetic is unsigned on magnitudes. The |80000000| magnitude must be
//  handled as an unsigned 32-bit value, with no overflow.
// TESTING
//  1. mult u 00000007*00000006 -> prodh=00000000 prodl=0000002A; done rises 33 cycles after start.
//  2. mult u FFFFFFFF*FFFFFFFF -> FFFFFFFE 00000001.
//     mult s FFFFFFFF*00000002 -> FFFFFFFF FFFFFFFE.
//     mult s 80000000*80000000 -> 40000000 00000000.
//  3. div s FFFFFFF9/00000002 -> prodl=FFFFFFFD, prodh=FFFFFFFF.
//     div u 00000064/00000007 -> prodl=0000000E, prodh=00000002.
//  4. div u/s 12345678/00000000 -> dividebyzero=1, prodl=FFFFFFFF, prodh=12345678.
//     Next valid divide clears the flag.
//  5. Start pulsed again 10 cycles into a mult -> ignored; original result and latency unchanged.
//  6. Reset asserted 15 cycles into an operation -> next cycle done=0, prodh=prodl=0.
//     A fresh start after reset returns the correct result.

Source files
------------

// File: rtl/serial_multdiv.sv
// Iterative multiply/divide unit: one product or quotient bit per clock.
// Ports: clk, reset, start, multdivb, signedop, x, y -> prodh, prodl, done, dividebyzero.
module serial_multdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             multdivb,
    input  logic             signedop,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] prodh,
    output logic [WIDTH-1:0] prodl,
    output logic             done,
    output logic             dividebyzero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               mul_q, mul_d;
    logic               sgn_q, sgn_d;
    logic               sx_q, sx_d;
    logic               sy_q, sy_d;
    logic               yzero_q, yzero_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   xraw_q, xraw_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   prodh_q, prodh_d;
    logic [WIDTH-1:0]   prodl_q, prodl_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               accept;
    logic [WIDTH-1:0]   x_mag, y_mag;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH:0]     rem_sh, rem_sub;
    logic               rem_ge;
    logic [2*WIDTH-1:0] div_acc;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo, rem;

    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

    // Magnitudes stay unsigned, so |80000000| is simply 80000000.
    assign x_mag = (signedop && x[WIDTH-1]) ? -x : x;
    assign y_mag = (signedop && y[WIDTH-1]) ? -y : y;

    // Multiply: MSB-first shift-add; a_q supplies multiplier bits.
    assign mul_acc = {acc_q[2*WIDTH-2:0], 1'b0}
                   + (a_q[WIDTH-1] ? {{WIDTH{1'b0}}, b_q} : '0);

    // Divide: remainder in the upper half, quotient shifts into the lower half.
    assign rem_sh  = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, b_q};
    assign rem_ge  = rem_sh >= {1'b0, b_q};
    assign div_acc = {rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0],
                      acc_q[WIDTH-2:0], rem_ge};

    assign prod_neg = -acc_q;
    assign quo = (sgn_q && (sx_q ^ sy_q)) ? -acc_q[WIDTH-1:0]
                                         : acc_q[WIDTH-1:0];
    assign rem = (sgn_q && sx_q) ? -acc_q[2*WIDTH-1:WIDTH]
                                 : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        mul_d   = mul_q;
        sgn_d   = sgn_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        yzero_d = yzero_q;
        a_d     = a_q;
        b_d     = b_q;
        xraw_d  = xraw_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prodh_d = prodh_q;
        prodl_d = prodl_q;
        done_d  = done_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    mul_d   = multdivb;
                    sgn_d   = signedop;
                    sx_d    = signedop & x[WIDTH-1];
                    sy_d    = signedop & y[WIDTH-1];
                    yzero_d = (y == '0);
                    a_d     = x_mag;
                    b_d     = y_mag;
                    xraw_d  = x;
                    acc_d   = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = mul_q ? mul_acc : div_acc;
                a_d   = {a_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (mul_q) begin
                    {prodh_d, prodl_d} = (sgn_q && (sx_q ^ sy_q)) ? prod_neg
                                                                 : acc_q;
                    dbz_d = 1'b0;
                end else if (yzero_q) begin
                    prodh_d = xraw_q;
                    prodl_d = '1;
                    dbz_d   = 1'b1;
                end else begin
                    prodh_d = rem;
                    prodl_d = quo;
                    dbz_d   = 1'b0;
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mul_q   <= 1'b0;
            sgn_q   <= 1'b0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            yzero_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            xraw_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prodh_q <= '0;
            prodl_q <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mul_q   <= mul_d;
            sgn_q   <= sgn_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            yzero_q <= yzero_d;
            a_q     <= a_d;
            b_q     <= b_d;
            xraw_q  <= xraw_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prodh_q <= prodh_d;
            prodl_q <= prodl_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign prodh        = prodh_q;
    assign prodl        = prodl_q;
    assign done         = done_q;
    assign dividebyzero = dbz_q;

endmodule

// File: tb/tb_serial_multdiv.sv
// Scoreboard bench for serial_multdiv.
// Expected results are queued at start and compared when done rises.
module tb_serial_multdiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        multdivb;
    logic        signedop;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] prodh;
    logic [31:0] prodl;
    logic        done;
    logic        dividebyzero;

    typedef struct {
        logic [31:0] h;
        logic [31:0] l;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    serial_multdiv #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multdivb     (multdivb),
        .signedop     (signedop),
        .x            (x),
        .y            (y),
        .prodh        (prodh),
        .prodl        (prodl),
        .done         (done),
        .dividebyzero (dividebyzero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic m, input logic s,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [63:0] p;
        logic signed [31:0] sa, sb_;
        logic [31:0] q, r;
        sa  = a;
        sb_ = b;
        e.dbz = 1'b0;
        if (m) begin
            if (s) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            else   p = {32'd0, a} * {32'd0, b};
            e.h = p[63:32];
            e.l = p[31:0];
        end else if (b == 32'd0) begin
            e.dbz = 1'b1;
            e.h   = a;
            e.l   = 32'hFFFF_FFFF;
        end else begin
            if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else if (s) begin
                q = sa / sb_;
                r = sa % sb_;
            end else begin
                q = a / b;
                r = a % b;
            end
            e.h = r;
            e.l = q;
        end
        return e;
    endfunction

    // glitch: cycle at which a stray start is pulsed (0 = none)
    // rst_at: cycle at which reset aborts the op (0 = none)
    task automatic run_op(input string tag, input logic m, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          input int glitch, input int rst_at);
        exp_t e;
        int   cyc;
        logic early;
        if (rst_at == 0) sb.push_back(model(m, s, a, b));
        @(negedge clk);
        multdivb = m;
        signedop = s;
        x        = a;
        y        = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        early = 1'b0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst_at != 0 && cyc == rst_at + 1) begin
                reset = 1'b0;
                chk({tag, " rst done"}, {63'd0, done}, 64'd0);
                chk({tag, " rst prod"}, {prodh, prodl}, 64'd0);
                return;
            end
            if (done) break;
            if (prodh !== 32'd0 || prodl !== 32'd0) early = early;
            if (cyc == glitch) begin
                start    = 1'b1;
                multdivb = ~m;
                x        = $urandom;
                y        = $urandom;
            end else begin
                start = 1'b0;
            end
            if (rst_at != 0 && cyc == rst_at) reset = 1'b1;
        end
        start = 1'b0;
        chk({tag, " latency"}, 64'(cyc), 64'd33);
        if (sb.size() == 0) begin
            chk({tag, " sb empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, " prod"}, {prodh, prodl}, {e.h, e.l});
        chk({tag, " dbz"}, {63'd0, dividebyzero}, {63'd0, e.dbz});
    endtask

    initial begin
        logic [31:0] hh, ll;
        reset    = 1'b1;
        start    = 1'b0;
        multdivb = 1'b0;
        signedop = 1'b0;
        x        = '0;
        y        = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset prod", {prodh, prodl}, 64'd0);
        chk("reset dbz", {63'd0, dividebyzero}, 64'd0);
        reset = 1'b0;

        run_op("mul 7*6", 1, 0, 32'h7, 32'h6, 0, 0);
        hh = prodh;
        ll = prodl;
        repeat (4) @(posedge clk);
        #1;
        chk("hold prod", {prodh, prodl}, {hh, ll});
        chk("hold done", {63'd0, done}, 64'd1);

        run_op("mulu ff*ff", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op("muls -1*2", 1, 1, 32'hFFFF_FFFF, 32'h2, 0, 0);
        run_op("muls min*min", 1, 1, 32'h8000_0000, 32'h8000_0000, 0, 0);
        run_op("divs -7/2", 0, 1, 32'hFFFF_FFF9, 32'h2, 0, 0);
        run_op("divu 100/7", 0, 0, 32'h64, 32'h7, 0, 0);
        run_op("divu /0", 0, 0, 32'h1234_5678, 32'h0, 0, 0);
        run_op("divu ok", 0, 0, 32'h64, 32'h7, 0, 0);
        run_op("divs /0", 0, 1, 32'h1234_5678, 32'h0, 0, 0);
        run_op("divs min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op("divs 7/-2", 0, 1, 32'h7, 32'hFFFF_FFFE, 0, 0);
        run_op("mul glitch", 1, 0, 32'h0001_2345, 32'h0000_6789, 10, 0);
        run_op("reset abort", 1, 1, 32'hDEAD_BEEF, 32'h1234_5678, 0, 15);
        run_op("after rst", 1, 1, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("rand%0d", i), 1'($urandom_range(1)),
                   1'($urandom_range(1)), $urandom, $urandom, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
